// File: rtl/priority_encoder_sync.sv
// Priority encoder built as a log2-depth binary reduction tree over a request
// vector zero-padded to a power of two, with optional registered outputs.
module priority_encoder_sync #(
  parameter int WIDTH             = 4,
  parameter int LSB_HIGH_PRIORITY = 0,
  parameter int REG_OUTPUT        = 0,
  localparam int EW               = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_unencoded,
  output logic             output_valid,
  output logic [EW-1:0]    output_encoded,
  output logic [WIDTH-1:0] output_unencoded
);

  localparam int P = 1 << EW;

  // Heap-ordered tree: node k has children 2k (lower half) and 2k+1 (upper half);
  // leaves sit at P..2P-1, root at 1.
  logic [2*P-1:1] tree_vld;
  logic [EW-1:0]  tree_idx [1:2*P-1];

  logic             valid_d;
  logic [EW-1:0]    encoded_d;
  logic [WIDTH-1:0] unencoded_d;

  for (genvar j = 0; j < P; j++) begin : g_leaf
    if (j < WIDTH) begin : g_real
      assign tree_vld[P+j] = input_unencoded[j];
    end else begin : g_pad
      assign tree_vld[P+j] = 1'b0;
    end
    assign tree_idx[P+j] = '0;
  end

  for (genvar k = 1; k < P; k++) begin : g_node
    // Height above the leaves; this node contributes index bit H-1.
    localparam int H = EW - ($clog2(k + 1) - 1);
    logic sel_hi;

    if (LSB_HIGH_PRIORITY != 0) begin : g_lsb
      assign sel_hi = tree_vld[2*k+1] & ~tree_vld[2*k];
    end else begin : g_msb
      assign sel_hi = tree_vld[2*k+1];
    end

    assign tree_vld[k] = tree_vld[2*k] | tree_vld[2*k+1];
    assign tree_idx[k] = (sel_hi ? tree_idx[2*k+1] : tree_idx[2*k])
                       | (EW'(sel_hi) << (H - 1));
  end

  // Stage p0: root of the tree and one-hot expansion
  assign valid_d   = tree_vld[1];
  assign encoded_d = tree_idx[1];

  always_comb begin
    unencoded_d = '0;
    if (valid_d) begin
      unencoded_d = WIDTH'(1) << encoded_d;
    end
  end

  if (REG_OUTPUT != 0) begin : g_reg
    logic             valid_q;
    logic [EW-1:0]    encoded_q;
    logic [WIDTH-1:0] unencoded_q;

    // Stage p1: registered outputs, one result per cycle
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q     <= 1'b0;
        encoded_q   <= '0;
        unencoded_q <= '0;
      end else begin
        valid_q     <= valid_d;
        encoded_q   <= encoded_d;
        unencoded_q <= unencoded_d;
      end
    end

    assign output_valid     = valid_q;
    assign output_encoded   = encoded_q;
    assign output_unencoded = unencoded_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign output_valid     = valid_d;
    assign output_encoded   = encoded_d;
    assign output_unencoded = unencoded_d;
  end

endmodule

// File: tb/tb_priority_encoder_sync.sv
// Directed and random checks of priority_encoder_sync across widths, priority
// orders and both output modes.
module tb_priority_encoder_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks   = 0;
  int failures = 0;

  logic [0:0]  in1;
  logic [1:0]  in2;
  logic [2:0]  in3;
  logic [4:0]  in5;
  logic [63:0] in64;
  logic [69:0] in70;
  logic [7:0]  in8;
  logic [15:0] in16;

  logic s1m_v, s1l_v, s2m_v, s2l_v, s3m_v, s3l_v, s5m_v, s5l_v;
  logic s64m_v, s64l_v, s70m_v, s70l_v, u8m_v, u8l_v, u16r_v;
  logic [0:0] s1m_e, s1l_e, s2m_e, s2l_e;
  logic [1:0] s3m_e, s3l_e;
  logic [2:0] s5m_e, s5l_e, u8m_e, u8l_e;
  logic [5:0] s64m_e, s64l_e;
  logic [6:0] s70m_e, s70l_e;
  logic [3:0] u16r_e;
  logic [0:0]  s1m_u, s1l_u;
  logic [1:0]  s2m_u, s2l_u;
  logic [2:0]  s3m_u, s3l_u;
  logic [4:0]  s5m_u, s5l_u;
  logic [63:0] s64m_u, s64l_u;
  logic [69:0] s70m_u, s70l_u;
  logic [7:0]  u8m_u, u8l_u;
  logic [15:0] u16r_u;

  priority_encoder_sync #(.WIDTH(1), .LSB_HIGH_PRIORITY(0)) i_s1m (.clk(clk), .rst(rst),
    .input_unencoded(in1), .output_valid(s1m_v), .output_encoded(s1m_e), .output_unencoded(s1m_u));
  priority_encoder_sync #(.WIDTH(1), .LSB_HIGH_PRIORITY(1)) i_s1l (.clk(clk), .rst(rst),
    .input_unencoded(in1), .output_valid(s1l_v), .output_encoded(s1l_e), .output_unencoded(s1l_u));
  priority_encoder_sync #(.WIDTH(2), .LSB_HIGH_PRIORITY(0)) i_s2m (.clk(clk), .rst(rst),
    .input_unencoded(in2), .output_valid(s2m_v), .output_encoded(s2m_e), .output_unencoded(s2m_u));
  priority_encoder_sync #(.WIDTH(2), .LSB_HIGH_PRIORITY(1)) i_s2l (.clk(clk), .rst(rst),
    .input_unencoded(in2), .output_valid(s2l_v), .output_encoded(s2l_e), .output_unencoded(s2l_u));
  priority_encoder_sync #(.WIDTH(3), .LSB_HIGH_PRIORITY(0)) i_s3m (.clk(clk), .rst(rst),
    .input_unencoded(in3), .output_valid(s3m_v), .output_encoded(s3m_e), .output_unencoded(s3m_u));
  priority_encoder_sync #(.WIDTH(3), .LSB_HIGH_PRIORITY(1)) i_s3l (.clk(clk), .rst(rst),
    .input_unencoded(in3), .output_valid(s3l_v), .output_encoded(s3l_e), .output_unencoded(s3l_u));
  priority_encoder_sync #(.WIDTH(5), .LSB_HIGH_PRIORITY(0)) i_s5m (.clk(clk), .rst(rst),
    .input_unencoded(in5), .output_valid(s5m_v), .output_encoded(s5m_e), .output_unencoded(s5m_u));
  priority_encoder_sync #(.WIDTH(5), .LSB_HIGH_PRIORITY(1)) i_s5l (.clk(clk), .rst(rst),
    .input_unencoded(in5), .output_valid(s5l_v), .output_encoded(s5l_e), .output_unencoded(s5l_u));
  priority_encoder_sync #(.WIDTH(64), .LSB_HIGH_PRIORITY(0)) i_s64m (.clk(clk), .rst(rst),
    .input_unencoded(in64), .output_valid(s64m_v), .output_encoded(s64m_e), .output_unencoded(s64m_u));
  priority_encoder_sync #(.WIDTH(64), .LSB_HIGH_PRIORITY(1)) i_s64l (.clk(clk), .rst(rst),
    .input_unencoded(in64), .output_valid(s64l_v), .output_encoded(s64l_e), .output_unencoded(s64l_u));
  priority_encoder_sync #(.WIDTH(70), .LSB_HIGH_PRIORITY(0)) i_s70m (.clk(clk), .rst(rst),
    .input_unencoded(in70), .output_valid(s70m_v), .output_encoded(s70m_e), .output_unencoded(s70m_u));
  priority_encoder_sync #(.WIDTH(70), .LSB_HIGH_PRIORITY(1)) i_s70l (.clk(clk), .rst(rst),
    .input_unencoded(in70), .output_valid(s70l_v), .output_encoded(s70l_e), .output_unencoded(s70l_u));
  priority_encoder_sync #(.WIDTH(8), .LSB_HIGH_PRIORITY(0)) i_u8m (.clk(clk), .rst(rst),
    .input_unencoded(in8), .output_valid(u8m_v), .output_encoded(u8m_e), .output_unencoded(u8m_u));
  priority_encoder_sync #(.WIDTH(8), .LSB_HIGH_PRIORITY(1)) i_u8l (.clk(clk), .rst(rst),
    .input_unencoded(in8), .output_valid(u8l_v), .output_encoded(u8l_e), .output_unencoded(u8l_u));
  priority_encoder_sync #(.WIDTH(16), .LSB_HIGH_PRIORITY(0), .REG_OUTPUT(1)) i_u16r (.clk(clk), .rst(rst),
    .input_unencoded(in16), .output_valid(u16r_v), .output_encoded(u16r_e), .output_unencoded(u16r_u));

  // Sweep instances gathered into arrays; even slots MSB-first, odd slots LSB-first.
  logic [127:0] sin [12];
  logic         sv  [12];
  logic [6:0]   se  [12];
  logic [127:0] su  [12];
  int sw_w [12] = '{1, 1, 2, 2, 3, 3, 5, 5, 64, 64, 70, 70};

  assign sin[0] = 128'(in1);  assign sin[1] = 128'(in1);
  assign sin[2] = 128'(in2);  assign sin[3] = 128'(in2);
  assign sin[4] = 128'(in3);  assign sin[5] = 128'(in3);
  assign sin[6] = 128'(in5);  assign sin[7] = 128'(in5);
  assign sin[8] = 128'(in64); assign sin[9] = 128'(in64);
  assign sin[10] = 128'(in70); assign sin[11] = 128'(in70);
  assign sv[0] = s1m_v;  assign sv[1] = s1l_v;  assign sv[2] = s2m_v;   assign sv[3] = s2l_v;
  assign sv[4] = s3m_v;  assign sv[5] = s3l_v;  assign sv[6] = s5m_v;   assign sv[7] = s5l_v;
  assign sv[8] = s64m_v; assign sv[9] = s64l_v; assign sv[10] = s70m_v; assign sv[11] = s70l_v;
  assign se[0] = 7'(s1m_e);  assign se[1] = 7'(s1l_e);  assign se[2] = 7'(s2m_e);   assign se[3] = 7'(s2l_e);
  assign se[4] = 7'(s3m_e);  assign se[5] = 7'(s3l_e);  assign se[6] = 7'(s5m_e);   assign se[7] = 7'(s5l_e);
  assign se[8] = 7'(s64m_e); assign se[9] = 7'(s64l_e); assign se[10] = s70m_e;     assign se[11] = s70l_e;
  assign su[0] = 128'(s1m_u);  assign su[1] = 128'(s1l_u);  assign su[2] = 128'(s2m_u);   assign su[3] = 128'(s2l_u);
  assign su[4] = 128'(s3m_u);  assign su[5] = 128'(s3l_u);  assign su[6] = 128'(s5m_u);   assign su[7] = 128'(s5l_u);
  assign su[8] = 128'(s64m_u); assign su[9] = 128'(s64l_u); assign su[10] = 128'(s70m_u); assign su[11] = 128'(s70l_u);

  // Linear-scan reference
  function automatic void ref_model(input logic [127:0] v, input int w, input bit lsb,
                                    output logic ev, output int ee, output logic [127:0] eu);
    ev = 1'b0;
    ee = 0;
    eu = '0;
    for (int i = 0; i < w; i++) begin
      if (v[i]) begin
        if (!ev || !lsb) ee = i;
        ev = 1'b1;
      end
    end
    if (ev) eu[ee] = 1'b1;
  endfunction

  task automatic test_reset;
    rst  = 1'b1;
    in16 = 16'hFFFF;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (u16r_v !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0h expected 0", u16r_v); end
    checks++;
    if (u16r_e !== 4'd0) begin failures++; $display("FAIL reset_encoded: got %0h expected 0", u16r_e); end
    checks++;
    if (u16r_u !== 16'h0) begin failures++; $display("FAIL reset_unencoded: got %0h expected 0", u16r_u); end
  endtask

  task automatic test_zero_input;
    in1 = '0; in2 = '0; in3 = '0; in5 = '0; in64 = '0; in70 = '0;
    #1;
    for (int j = 0; j < 12; j++) begin
      checks++;
      if (sv[j] !== 1'b0 || se[j] !== 7'd0 || su[j] !== 128'd0) begin
        failures++;
        $display("FAIL zero_input slot %0d: got v=%0h e=%0h u=%0h expected all 0", j, sv[j], se[j], su[j]);
      end
    end
  endtask

  task automatic test_all_ones_64;
    in64 = '1;
    #1;
    checks++;
    if (s64m_v !== 1'b1 || s64m_e !== 6'd63) begin
      failures++; $display("FAIL ones64_msb: got v=%0h e=%0d expected v=1 e=63", s64m_v, s64m_e);
    end
    checks++;
    if (s64m_u !== 64'h8000_0000_0000_0000) begin
      failures++; $display("FAIL ones64_msb_onehot: got %0h expected 8000000000000000", s64m_u);
    end
    checks++;
    if (s64l_e !== 6'd0 || s64l_u !== 64'h1) begin
      failures++; $display("FAIL ones64_lsb: got e=%0d u=%0h expected e=0 u=1", s64l_e, s64l_u);
    end
  endtask

  task automatic test_width70;
    in70 = 70'h3F_FFFF;
    #1;
    checks++;
    if (s70m_v !== 1'b1 || s70m_e !== 7'd21) begin
      failures++; $display("FAIL w70_tkeep22: got v=%0h e=%0d expected v=1 e=21", s70m_v, s70m_e);
    end
    checks++;
    if (s70m_u !== 70'h20_0000) begin
      failures++; $display("FAIL w70_tkeep22_onehot: got %0h expected 200000", s70m_u);
    end
    in70 = {1'b1, 69'h0_0000_0000_0000_1000};
    #1;
    checks++;
    if (s70m_e !== 7'd69 || s70l_e !== 7'd12) begin
      failures++; $display("FAIL w70_top_bit: got msb_e=%0d lsb_e=%0d expected 69 12", s70m_e, s70l_e);
    end
    checks++;
    if (s70l_u !== 70'h1000) begin
      failures++; $display("FAIL w70_lsb_onehot: got %0h expected 1000", s70l_u);
    end
  endtask

  task automatic test_width8_both_priorities;
    in8 = 8'b0110_1000;
    #1;
    checks++;
    if (u8l_v !== 1'b1 || u8l_e !== 3'd3 || u8l_u !== 8'b0000_1000) begin
      failures++; $display("FAIL w8_lsb: got v=%0h e=%0d u=%0h expected v=1 e=3 u=08", u8l_v, u8l_e, u8l_u);
    end
    checks++;
    if (u8m_v !== 1'b1 || u8m_e !== 3'd6 || u8m_u !== 8'b0100_0000) begin
      failures++; $display("FAIL w8_msb: got v=%0h e=%0d u=%0h expected v=1 e=6 u=40", u8m_v, u8m_e, u8m_u);
    end
    in8 = 8'b1000_0001;
    #1;
    checks++;
    if (u8m_e !== 3'd7 || u8l_e !== 3'd0) begin
      failures++; $display("FAIL w8_ends: got msb_e=%0d lsb_e=%0d expected 7 0", u8m_e, u8l_e);
    end
  endtask

  task automatic test_width1;
    in1 = 1'b1;
    #1;
    checks++;
    if (s1m_v !== 1'b1 || s1m_e !== 1'b0 || s1m_u !== 1'b1 || s1l_v !== 1'b1 || s1l_e !== 1'b0) begin
      failures++; $display("FAIL w1_set: got v=%0h e=%0h u=%0h expected v=1 e=0 u=1", s1m_v, s1m_e, s1m_u);
    end
    in1 = 1'b0;
    #1;
    checks++;
    if (s1m_v !== 1'b0 || s1l_v !== 1'b0 || s1m_u !== 1'b0) begin
      failures++; $display("FAIL w1_clear: got v=%0h u=%0h expected 0 0", s1m_v, s1m_u);
    end
  endtask

  task automatic test_tkeep_popcount;
    for (int k = 1; k <= 64; k++) begin
      in64 = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - k);
      #1;
      checks++;
      if (s64m_v !== 1'b1 || s64m_e !== 6'(k - 1)) begin
        failures++; $display("FAIL tkeep_k%0d: got v=%0h e=%0d expected v=1 e=%0d", k, s64m_v, s64m_e, k - 1);
      end
    end
  endtask

  task automatic test_comb_ignores_reset;
    in8 = 8'b0110_1000;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (u8m_v !== 1'b1 || u8m_e !== 3'd6) begin
      failures++; $display("FAIL comb_under_rst: got v=%0h e=%0d expected v=1 e=6", u8m_v, u8m_e);
    end
    in8 = 8'h01;
    #1;
    checks++;
    if (u8m_e !== 3'd0 || u8m_u !== 8'h01) begin
      failures++; $display("FAIL comb_follow_under_rst: got e=%0d u=%0h expected e=0 u=01", u8m_e, u8m_u);
    end
  endtask

  task automatic test_reg_stream;
    // Leaves rst asserted from the previous task; release and stream three words.
    @(posedge clk);
    #1;
    rst  = 1'b0;
    in16 = 16'h0001;
    #1;
    checks++;
    if (u16r_v !== 1'b0 || u16r_u !== 16'h0) begin
      failures++; $display("FAIL reg_no_comb_path: got v=%0h u=%0h expected 0 0", u16r_v, u16r_u);
    end
    @(posedge clk);
    #1;
    checks++;
    if (u16r_v !== 1'b1 || u16r_e !== 4'd0 || u16r_u !== 16'h0001) begin
      failures++; $display("FAIL reg_word0: got v=%0h e=%0d u=%0h expected 1 0 0001", u16r_v, u16r_e, u16r_u);
    end
    in16 = 16'h8000;
    @(posedge clk);
    #1;
    checks++;
    if (u16r_v !== 1'b1 || u16r_e !== 4'd15 || u16r_u !== 16'h8000) begin
      failures++; $display("FAIL reg_word1: got v=%0h e=%0d u=%0h expected 1 15 8000", u16r_v, u16r_e, u16r_u);
    end
    in16 = 16'h0000;
    @(posedge clk);
    #1;
    checks++;
    if (u16r_v !== 1'b0 || u16r_e !== 4'd0 || u16r_u !== 16'h0) begin
      failures++; $display("FAIL reg_word2: got v=%0h e=%0d u=%0h expected 0 0 0000", u16r_v, u16r_e, u16r_u);
    end
  endtask

  task automatic test_midstream_reset;
    in16 = 16'h0010;
    @(posedge clk);
    #1;
    checks++;
    if (u16r_v !== 1'b1 || u16r_e !== 4'd4) begin
      failures++; $display("FAIL mid_pre: got v=%0h e=%0d expected 1 4", u16r_v, u16r_e);
    end
    in16 = 16'h0100;
    rst  = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (u16r_v !== 1'b0 || u16r_e !== 4'd0 || u16r_u !== 16'h0) begin
      failures++; $display("FAIL mid_rst: got v=%0h e=%0d u=%0h expected 0 0 0000", u16r_v, u16r_e, u16r_u);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (u16r_v !== 1'b1 || u16r_e !== 4'd8 || u16r_u !== 16'h0100) begin
      failures++; $display("FAIL mid_post: got v=%0h e=%0d u=%0h expected 1 8 0100", u16r_v, u16r_e, u16r_u);
    end
  endtask

  task automatic test_back_to_back;
    logic         ev;
    int           ee;
    logic [127:0] eu;
    logic [15:0]  x;
    for (int it = 0; it < 60; it++) begin
      x = 16'($urandom);
      if (it % 4 == 1) x = x & 16'($urandom) & 16'($urandom);
      if (it % 7 == 3) x = 16'h0;
      in16 = x;
      @(posedge clk);
      #1;
      ref_model(128'(x), 16, 1'b0, ev, ee, eu);
      checks++;
      if (u16r_v !== ev || u16r_e !== 4'(ee) || u16r_u !== eu[15:0]) begin
        failures++;
        $display("FAIL b2b in=%0h: got v=%0h e=%0d u=%0h expected v=%0h e=%0d u=%0h",
                 x, u16r_v, u16r_e, u16r_u, ev, ee, eu[15:0]);
      end
    end
  endtask

  task automatic test_random_sweep;
    logic         ev;
    int           ee;
    logic [127:0] eu;
    logic [127:0] r;
    for (int it = 0; it < 300; it++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      case (it % 5)
        1: r = r & {$urandom, $urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom, $urandom};
        2: r = 128'd1 << $urandom_range(0, 127);
        3: r = '0;
        4: r = {128{1'b1}} >> $urandom_range(0, 127);
        default: ;
      endcase
      in1 = r[0:0]; in2 = r[1:0]; in3 = r[2:0]; in5 = r[4:0]; in64 = r[63:0]; in70 = r[69:0];
      #1;
      for (int j = 0; j < 12; j++) begin
        ref_model(sin[j], sw_w[j], bit'(j % 2), ev, ee, eu);
        checks++;
        if (sv[j] !== ev || se[j] !== 7'(ee) || su[j] !== eu) begin
          failures++;
          $display("FAIL sweep w=%0d lsb=%0d in=%0h: got v=%0h e=%0d u=%0h expected v=%0h e=%0d u=%0h",
                   sw_w[j], j % 2, sin[j], sv[j], se[j], su[j], ev, ee, eu);
        end
      end
      #4;
    end
  endtask

  initial begin
    in1 = '0; in2 = '0; in3 = '0; in5 = '0; in64 = '0; in70 = '0; in8 = '0; in16 = '0;
    test_reset();
    test_zero_input();
    test_all_ones_64();
    test_width70();
    test_width8_both_priorities();
    test_width1();
    test_tkeep_popcount();
    test_comb_ignores_reset();
    test_reg_stream();
    test_midstream_reset();
    test_back_to_back();
    test_random_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/priority_encoder_sync.md
PRIORITY_ENCODER_SYNC -- requirements
Module: priority_encoder_sync

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of request bits (legal range 1..1024).
REQ-002 The block SHALL have parameter LSB_HIGH_PRIORITY, default 0.
- 0: the highest set index wins.
- 1: the lowest set index wins.
REQ-003 The block SHALL have parameter REG_OUTPUT, default 0.
- 0: outputs combinational.
- 1: outputs registered.
REQ-004 Derived localparam EW SHALL equal $clog2(WIDTH) when WIDTH>2, else 1.
REQ-005 Port clk: input, 1 bit, clock; reset rst, synchronous, active-high; clock clk.
REQ-006 Port rst: input, 1 bit, synchronous active-high reset.
REQ-007 Port input_unencoded: input, WIDTH bits, request vector.
REQ-008 Port output_valid: output, 1 bit, at least one request bit set.
REQ-009 Port output_encoded: output, EW bits, index of the winning bit.
REQ-010 Port output_unencoded: output, WIDTH bits, one-hot of the winning bit.

Function
REQ-011 output_valid SHALL equal the OR-reduction of input_unencoded.
REQ-012 With LSB_HIGH_PRIORITY=0, output_encoded SHALL be the largest index i with input_unencoded[i]=1.
REQ-013 With LSB_HIGH_PRIORITY=1, output_encoded SHALL be the smallest index i with input_unencoded[i]=1.
REQ-014 output_unencoded SHALL equal 1<<output_encoded when output_valid=1.
REQ-015 output_unencoded SHALL equal 0 when output_valid=0.
REQ-016 When input_unencoded is all zero, output_encoded SHALL be 0 and output_valid SHALL be 0.
REQ-017 Non-power-of-two WIDTH SHALL be handled by zero-padding internally to 2^EW bits; padded bits never win.
REQ-018 Implementation SHALL be a log2-depth binary reduction tree, not a linear scan.
- Each node passes the winning child's valid flag and index.
- The index is extended by one MSB per level selecting the winning half.
REQ-019 When REG_OUTPUT=0:
- outputs SHALL follow input_unencoded combinationally with zero cycles latency;
- clk and rst SHALL have no effect.
REQ-020 When REG_OUTPUT=1:
- all three outputs SHALL be registered on the rising edge of clk;
- latency SHALL be exactly 1 cycle;
- a new input SHALL be accepted every cycle.
REQ-021 For a contiguous low-aligned mask (e.g. a tkeep pattern 0..0 1..1) with LSB_HIGH_PRIORITY=0, output_encoded SHALL equal popcount-1.
REQ-022 When WIDTH=1, output_encoded SHALL be 0 and output_valid SHALL equal input_unencoded[0].

Reset
REQ-023 With REG_OUTPUT=1, rst high at a clk edge SHALL clear output_valid, output_encoded and output_unencoded to 0.
REQ-024 A reset asserted mid-stream SHALL discard the in-flight result; the first valid result appears 1 cycle after rst deasserts.
REQ-025 With REG_OUTPUT=0, reset SHALL have no effect.

Verification
REQ-026 WIDTH=64, LSB_HIGH_PRIORITY=0, input all ones -> valid=1, encoded=63, unencoded=1<<63.
REQ-027 WIDTH=70, LSB_HIGH_PRIORITY=0, input=0x3F_FFFF (22 low ones) -> valid=1, encoded=21.
REQ-028 WIDTH=8, LSB_HIGH_PRIORITY=1, input=8'b0110_1000 -> encoded=3, unencoded=8'b0000_1000.
- Same input with LSB_HIGH_PRIORITY=0 -> encoded=6.
REQ-029 Any WIDTH, input=0 -> valid=0, encoded=0, unencoded=0.
REQ-030 REG_OUTPUT=1, WIDTH=16, rst then inputs 0x0001, 0x8000, 0x0000 on consecutive cycles -> encoded 0, 15, 0 one cycle later each, with valid 1, 1, 0.
- Asserting rst during the stream -> all outputs 0 on the next cycle.
REQ-031 Random sweep for WIDTH in {1,2,3,5,64,70} and both priority settings -> outputs match a reference scan model every cycle.
